// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared types and helpers for the commit-port fence sequencer
package ariane_pkg;

    // Encodings presented by commit logic on req_kind_i; values 5-7 are reserved.
    typedef enum logic [2:0] {
        FENCE       = 3'd0,
        FENCE_I     = 3'd1,
        SFENCE_VMA  = 3'd2,
        HFENCE_VVMA = 3'd3,
        HFENCE_GVMA = 3'd4
    } fence_kind_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH_REQ,
        DONE,
        ERR
    } fence_ctrl_state_e;

    // A kind is serviceable only if it is encoded and its privilege extension exists.
    function automatic logic is_fence_kind_valid(input logic [2:0] kind,
                                                 input logic       rvs,
                                                 input logic       rvh);
        logic ok;
        ok = 1'b0;
        case (kind)
            FENCE, FENCE_I:           ok = 1'b1;
            SFENCE_VMA:               ok = rvs;
            HFENCE_VVMA, HFENCE_GVMA: ok = rvh;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fence_drain_counter.sv
// rtl/fence_drain_counter.sv - saturating cycle counter with clear, enable and threshold compare
module fence_drain_counter #(
    parameter int unsigned StatWidth = 16,
    parameter int unsigned Timeout   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    output logic [StatWidth-1:0] count_next_o,
    output logic                 reach_o
);

    logic [StatWidth-1:0] count_q;
    logic [StatWidth-1:0] count_d;

    // Saturating increment; the incremented value is what callers latch as a completed count.
    assign count_d      = (&count_q) ? count_q : count_q + StatWidth'(1);
    assign count_next_o = count_d;
    assign reach_o      = (32'(count_d) >= Timeout);

    // Counter register: clear has priority over enable.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/commit_fence_ctrl.sv
// rtl/commit_fence_ctrl.sv - serialises fence-class commits: drain stores, flush handshake, done pulse
module commit_fence_ctrl
    import ariane_pkg::*;
#(
    parameter bit          RVS          = 1'b1,
    parameter bit          RVH          = 1'b1,
    parameter int unsigned DrainTimeout = 1024,
    parameter int unsigned StatWidth    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [2:0]           req_kind_i,
    output logic                 req_ready_o,
    input  logic                 flush_i,
    input  logic                 no_st_pending_i,
    output logic                 ctrl_flush_req_o,
    output logic [2:0]           ctrl_flush_kind_o,
    input  logic                 ctrl_flush_ack_i,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 busy_o,
    output logic                 drain_timeout_o,
    output logic [StatWidth-1:0] drain_cycles_o
);

    fence_ctrl_state_e    state_q;
    logic [2:0]           kind_q;
    logic                 abort_q;
    logic                 timeout_q;
    logic [StatWidth-1:0] drain_cycles_q;

    logic                 accept;
    logic                 cnt_en;
    logic [StatWidth-1:0] cnt_d;
    logic                 cnt_reach;

    assign accept = (state_q == IDLE) && req_valid_i && !flush_i;
    assign cnt_en = (state_q == DRAIN) && !flush_i;

    fence_drain_counter #(
        .StatWidth(StatWidth),
        .Timeout  (DrainTimeout)
    ) u_drain_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (accept),
        .en_i        (cnt_en),
        .count_next_o(cnt_d),
        .reach_o     (cnt_reach)
    );

    // Sequencer: one op at a time; an abort during the handshake is remembered until ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            kind_q         <= 3'd0;
            abort_q        <= 1'b0;
            timeout_q      <= 1'b0;
            drain_cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        kind_q    <= req_kind_i;
                        abort_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= is_fence_kind_valid(req_kind_i, RVS, RVH) ? DRAIN : ERR;
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        timeout_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        if (cnt_reach) begin
                            timeout_q <= 1'b1;
                        end
                        if (no_st_pending_i) begin
                            drain_cycles_q <= cnt_d;
                            state_q        <= FLUSH_REQ;
                        end
                    end
                end
                FLUSH_REQ: begin
                    if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                    if (ctrl_flush_ack_i) begin
                        timeout_q <= 1'b0;
                        abort_q   <= 1'b0;
                        state_q   <= (abort_q || flush_i) ? IDLE : DONE;
                    end
                end
                default: begin
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = (state_q == IDLE) && !flush_i;
    assign busy_o            = (state_q != IDLE);
    assign ctrl_flush_req_o  = (state_q == FLUSH_REQ);
    assign ctrl_flush_kind_o = (state_q == FLUSH_REQ) ? kind_q : 3'd0;
    assign done_o            = ((state_q == DONE) || (state_q == ERR)) && !flush_i;
    assign error_o           = (state_q == ERR) && !flush_i;
    assign drain_timeout_o   = timeout_q;
    assign drain_cycles_o    = drain_cycles_q;

endmodule
